// File: rtl/sc_pkg.sv
// sc_pkg: shared definitions for the single-cycle CPU front end.
//   PCSRC_*   next-PC select codes returned by the control unit
//   state_t   fetch FSM state encoding (FETCH / HOLD)
//   INST_NOP  all-zero word (sll $0,$0,0) presented while no instruction is held
//   align_word() clears the byte-offset bits of an address
package sc_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sc_npc_mux.sv
// sc_npc_mux: combinational next-PC selector.
// Ports:
//   pc4      in  32  sequential successor (pc + 4)
//   bpc      in  32  branch target
//   rpc      in  32  jr register target
//   jpc      in  32  jump target
//   pcsource in  2   select code (PCSRC_SEQ/BR/JR/J)
//   npc      out 32  selected target, word aligned
module sc_npc_mux
  import sc_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  logic [31:0] sel;

  always_comb begin
    sel = pc4;
    case (pcsource)
      PCSRC_SEQ: sel = pc4;
      PCSRC_BR:  sel = bpc;
      PCSRC_JR:  sel = rpc;
      PCSRC_J:   sel = jpc;
      default:   sel = pc4;
    endcase
  end

  // Register targets (jr) may be misaligned; the low bits are simply dropped.
  assign npc = align_word(sel);

endmodule

// File: rtl/sc_ifetch.sv
// sc_ifetch: instruction-fetch stage of the single-cycle CPU.
// Holds the PC, fetches one word per instruction over a req/ready handshake,
// holds it for decode/execute until commit, then advances the PC.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   imem_req/imem_addr      fetch request and byte address (== pc)
//   imem_rdata/imem_ready   returned word and completion strobe
//   pcsource,bpc,rpc,jpc    next-PC select and candidate targets
//   commit                  current instruction finished, advance PC
//   inst, op, func          held instruction (nop while inst_valid=0) and fields
//   pc, pc4, inst_valid     address of held instruction, pc+4, valid flag
// Optional build macro SC_IFETCH_PERF_EN adds fetch_cnt / wait_cnt counters.
module sc_ifetch
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        commit,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
`ifdef SC_IFETCH_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt,
`endif
  output logic        inst_valid
);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] npc;
  logic        fetch_acc;
  logic        fetch_wait;

  assign pc4 = pc + 32'd4;

  sc_npc_mux u_npc_mux (
    .pc4      (pc4),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .pcsource (pcsource),
    .npc      (npc)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    inst_nxt   = inst;
    fetch_acc  = 1'b0;
    fetch_wait = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          inst_nxt  = imem_rdata;
          state_nxt = HOLD;
          fetch_acc = 1'b1;
        end else begin
          fetch_wait = 1'b1;
        end
      end
      HOLD: begin
        if (commit) begin
          pc_nxt    = npc;
          inst_nxt  = INST_NOP;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      inst  <= INST_NOP;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
    end
  end

  // Request is masked while reset is asserted so memory sees no access
  // during the reset cycle even though the state already reads FETCH.
  assign imem_req   = (state == FETCH) && !reset;
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign op         = inst[31:26];
  assign func       = inst[5:0];

`ifdef SC_IFETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      wait_cnt  <= 32'd0;
    end else begin
      if (fetch_acc)  fetch_cnt <= fetch_cnt + 32'd1;
      if (fetch_wait) wait_cnt  <= wait_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = fetch_acc ^ fetch_wait;
`endif

endmodule

// File: tb/tb_sc_ifetch.sv
// Directed testbench for sc_ifetch with hand-computed expectations.
module tb_sc_ifetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        commit;
  logic [31:0] inst;
  logic [5:0]  op, func;
  logic [31:0] pc, pc4;
  logic        inst_valid;
`ifdef SC_IFETCH_PERF_EN
  logic [31:0] fetch_cnt, wait_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  sc_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .commit     (commit),
    .inst       (inst),
    .op         (op),
    .func       (func),
    .pc         (pc),
    .pc4        (pc4),
`ifdef SC_IFETCH_PERF_EN
    .fetch_cnt  (fetch_cnt),
    .wait_cnt   (wait_cnt),
`endif
    .inst_valid (inst_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past one rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One-cycle accepted fetch returning word w.
  task automatic fetch_one(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
    settle();
  endtask

  task automatic commit_with(input logic [1:0] src);
    pcsource = src;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    settle();
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    pcsource   = 2'b00;
    bpc        = 32'h0;
    rpc        = 32'h0;
    jpc        = 32'h0;
    commit     = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc",    pc,                  32'h0);

    // 1. Release with imem_ready tied high
    imem_ready = 1'b1;
    imem_rdata = 32'h8C22_0004;
    reset      = 1'b0;
    settle();
    chk("t1_req",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr,         32'h0);
    tick();
    imem_ready = 1'b0;
    settle();
    chk("t1_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst",  inst,                32'h8C22_0004);
    chk("t1_op",    {26'd0, op},         32'h23);
    chk("t1_func",  {26'd0, func},       32'h04);
    chk("t1_pc4",   pc4,                 32'h4);
    chk("t1_hreq",  {31'd0, imem_req},   32'd0);

    // 3. Redirects
    jpc = 32'h0000_0100;
    commit_with(2'b11);
    chk("t3_j_addr",  imem_addr,         32'h100);
    chk("t3_j_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3_j_inst",  inst,              32'h0);
    fetch_one(32'h0800_0004);
    bpc = 32'h0000_0040;
    commit_with(2'b01);
    chk("t3_br_addr", imem_addr, 32'h40);
    fetch_one(32'h0000_0008);
    rpc = 32'h0000_0083;
    commit_with(2'b10);
    chk("t3_jr_addr", imem_addr, 32'h80);
    fetch_one(32'h03E0_0008);

    // 2. Sequential flow from 0x10
    jpc = 32'h0000_0010;
    commit_with(2'b11);
    fetch_one(32'h0123_4820);
    chk("t2_pc",   pc,  32'h10);
    chk("t2_pc4",  pc4, 32'h14);
    chk("t2_func", {26'd0, func}, 32'h20);
    commit_with(2'b00);
    chk("t2_addr", imem_addr, 32'h14);

    // 5. Wrap and ignored inputs
    fetch_one(32'h0000_0000);
    jpc = 32'hFFFF_FFFC;
    commit_with(2'b11);
    fetch_one(32'h2108_0001);
    chk("t5_pc",  pc,  32'hFFFF_FFFC);
    chk("t5_pc4", pc4, 32'h0);
    // imem_ready/rdata ignored while holding
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    settle();
    chk("t5_hold_inst", inst, 32'h2108_0001);
    commit_with(2'b00);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    // commit ignored while fetching
    jpc = 32'h0000_0200;
    commit_with(2'b11);
    chk("t5_ign_addr", imem_addr,         32'h0);
    chk("t5_ign_req",  {31'd0, imem_req}, 32'd1);

    // 6. Reset mid-fetch with imem_ready=1
    fetch_one(32'h0000_0000);
    commit_with(2'b00);
    chk("t6_pre_addr", imem_addr, 32'h4);
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    reset      = 1'b1;
    tick();
    chk("t6_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_pc",    pc,                  32'h0);
    chk("t6_inst",  inst,                32'h0);
    chk("t6_req",   {31'd0, imem_req},   32'd0);
    imem_ready = 1'b0;
    reset      = 1'b0;
    settle();
    chk("t6_rereq",  {31'd0, imem_req}, 32'd1);
    chk("t6_readdr", imem_addr,         32'h0);

    // 4. Wait states
    imem_rdata = 32'hFC00_003F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_req",   {31'd0, imem_req},   32'd1);
      chk("t4_valid", {31'd0, inst_valid}, 32'd0);
      chk("t4_op",    {26'd0, op},         32'h0);
      chk("t4_func",  {26'd0, func},       32'h0);
    end
    fetch_one(32'hFC00_003F);
    chk("t4_inst", inst,          32'hFC00_003F);
    chk("t4_op2",  {26'd0, op},   32'h3F);
`ifdef SC_IFETCH_PERF_EN
    chk("t4_wait_cnt",  wait_cnt,  32'd3);
    chk("t4_fetch_cnt", fetch_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
